// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum phase is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted stream bytes into little-endian 32-bit words; the first
// byte of each group of four lands in word[7:0].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_stb,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int               IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-9:0] byte_hist;

    // The word completes together with its last byte, so the top level can
    // register the memory write on the same edge that accepts that byte.
    assign word_valid = byte_stb && (byte_idx == LAST_IDX);
    assign word       = {byte_in, byte_hist};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx  <= '0;
            byte_hist <= '0;
        end else if (clr) begin
            byte_idx  <= '0;
            byte_hist <= '0;
        end else if (byte_stb) begin
            byte_idx  <= byte_idx + IDX_W'(1);
            byte_hist <= word[WORD_W-1:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header word count, data words, optional
// trailing checksum (IMEM_LOADER_CHECKSUM_EN); holds the CPU until the load is done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int               CAP_W    = WORD_W + 1;
    localparam logic [CAP_W-1:0] CAPACITY = CAP_W'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e END_ST = CHK;
`else
    localparam state_e END_ST = DONE;
`endif

    state_e            state;
    state_e            state_nxt;
    logic              byte_stb;
    logic              pk_valid;
    logic [WORD_W-1:0] pk_word;
    logic              hdr_fire;
    logic              wr_fire;
    logic              last_hit;
    logic [ADDR_W-1:0] widx;
    logic [WORD_W-1:0] last_idx;

    // A restart in the same cycle as a handshake drops the byte.
    assign byte_stb = in_valid && in_ready && !restart;
    assign hdr_fire = pk_valid && (state == HDR);
    assign wr_fire  = pk_valid && (state == DATA);
    assign last_hit = (WORD_W'(widx) == last_idx);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .byte_stb   (byte_stb),
        .byte_in    (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (restart) begin
            csum <= '0;
        end else if (wr_fire) begin
            csum <= csum + pk_word;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = HDR;
        end else begin
            case (state)
                HDR: begin
                    if (pk_valid) begin
                        if (pk_word == '0)
                            state_nxt = END_ST;
                        else if ({1'b0, pk_word} > CAPACITY)
                            state_nxt = ERR;
                        else
                            state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (pk_valid && last_hit)
                        state_nxt = END_ST;
                end
                CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (pk_valid)
                        state_nxt = (pk_word == csum) ? DONE : ERR;
`else
                    state_nxt = ERR;
`endif
                end
                DONE:    state_nxt = DONE;
                ERR:     state_nxt = ERR;
                default: state_nxt = ERR;
            endcase
        end
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            imem_we  <= 1'b0;
            widx     <= '0;
            last_idx <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == CHK);
            cpu_hold <= (state_nxt != DONE);
            done     <= (state_nxt == DONE);
            err      <= (state_nxt == ERR);
            imem_we  <= wr_fire;
            if (restart)
                widx <= '0;
            else if (wr_fire)
                widx <= widx + ADDR_W'(1);
            if (hdr_fire)
                last_idx <= pk_word - WORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else if (wr_fire) begin
            imem_waddr <= widx;
            imem_wdata <= pk_word;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-word memory; checksum scenarios are
// selected by IMEM_LOADER_CHECKSUM_EN to match the build of the design.
module tb_imem_loader;

    localparam int ADDR_W = 4;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              restart  = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int nvec = 0;
    int nerr = 0;

    logic [ADDR_W-1:0] log_addr [64];
    logic [31:0]       log_data [64];
    int                wr_cnt = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    // Record every write strobe mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_cnt < 64) begin
            log_addr[wr_cnt] <= imem_waddr;
            log_data[wr_cnt] <= imem_wdata;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_restart();
        idle();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        nvec++; if (imem_we !== 1'b0) begin nerr++; $display("FAIL rst_imem_we: got %b want 0", imem_we); end
        nvec++; if (imem_waddr !== 4'h0) begin nerr++; $display("FAIL rst_waddr: got %h want 0", imem_waddr); end
        nvec++; if (imem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
        nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_release_ready_early: got %b want 0", in_ready); end
        step();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_load3();
        logic [31:0] exp_w [3];
        int base;
        exp_w[0] = 32'h0000_0013;
        exp_w[1] = 32'h0010_0093;
        exp_w[2] = 32'hDEAD_BEEF;
        base = wr_cnt;
        send_word(32'd3);
        for (int i = 0; i < 3; i++) send_word(exp_w[i]);
        idle();
        nvec++; if (imem_we !== 1'b1) begin nerr++; $display("FAIL load3_last_we: got %b want 1", imem_we); end
        nvec++; if (imem_waddr !== 4'd2) begin nerr++; $display("FAIL load3_last_addr: got %0d want 2", imem_waddr); end
        nvec++; if (imem_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL load3_last_data: got %h want deadbeef", imem_wdata); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        nvec++; if (done !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL load3_chk_wait: got done=%b ready=%b want done=0 ready=1", done, in_ready); end
        send_word(32'hDEBD_BF95);
        idle();
`endif
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL load3_done: got %b want 1", done); end
        nvec++; if (cpu_hold !== 1'b0) begin nerr++; $display("FAIL load3_cpu_hold: got %b want 0", cpu_hold); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL load3_in_ready: got %b want 0", in_ready); end
        step();
        nvec++; if (imem_we !== 1'b0) begin nerr++; $display("FAIL load3_we_single: got %b want 0", imem_we); end
        nvec++; if (wr_cnt - base !== 3) begin nerr++; $display("FAIL load3_write_count: got %0d want 3", wr_cnt - base); end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (log_addr[base+i] !== ADDR_W'(i) || log_data[base+i] !== exp_w[i]) begin
                nerr++;
                $display("FAIL load3_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         i, log_addr[base+i], log_data[base+i], i, exp_w[i]);
            end
        end
    endtask

    task automatic test_zero();
        int base;
        do_restart();
        nvec++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL zero_restart: got ready=%b hold=%b done=%b want 1 1 0", in_ready, cpu_hold, done); end
        base = wr_cnt;
        send_word(32'd0);
        idle();
`ifdef IMEM_LOADER_CHECKSUM_EN
        nvec++; if (done !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL zero_chk_wait: got done=%b ready=%b want done=0 ready=1", done, in_ready); end
        send_word(32'd0);
        idle();
`endif
        nvec++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin nerr++; $display("FAIL zero_done: got done=%b hold=%b want done=1 hold=0", done, cpu_hold); end
        step();
        nvec++; if (wr_cnt !== base) begin nerr++; $display("FAIL zero_no_writes: got %0d writes want 0", wr_cnt - base); end
    endtask

    task automatic test_oversize();
        int base;
        do_restart();
        base = wr_cnt;
        send_word(32'd17);
        idle();
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL over_err: got %b want 1", err); end
        nvec++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL over_status: got hold=%b ready=%b done=%b want 1 0 0", cpu_hold, in_ready, done); end
        send_byte(8'hAA);
        idle();
        step();
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL over_terminal: got err=%b want 1", err); end
        nvec++; if (wr_cnt !== base) begin nerr++; $display("FAIL over_no_writes: got %0d writes want 0", wr_cnt - base); end
        do_restart();
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL over_restart_clear: got err=%b want 0", err); end
        send_word(32'd16);
        idle();
        nvec++; if (err !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL over_boundary16: got err=%b ready=%b want err=0 ready=1", err, in_ready); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_restart();
        send_word(32'd2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd3);
        idle();
        nvec++; if (done !== 1'b1 || err !== 1'b0) begin nerr++; $display("FAIL csum_good: got done=%b err=%b want done=1 err=0", done, err); end
        do_restart();
        send_word(32'd2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd4);
        idle();
        nvec++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL csum_bad: got err=%b hold=%b done=%b want 1 1 0", err, cpu_hold, done); end
    endtask
`endif

    task automatic test_restart();
        int base;
        do_restart();
        base = wr_cnt;
        send_word(32'd2);
        send_word(32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        in_valid = 1'b1;
        in_data  = 8'h77;
        restart  = 1'b1;
        step();
        restart = 1'b0;
        idle();
        nvec++; if (imem_we !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL rs_abort: got we=%b hold=%b ready=%b done=%b want 0 1 1 0", imem_we, cpu_hold, in_ready, done); end
        step();
        nvec++; if (wr_cnt - base !== 1 || log_addr[base] !== 4'd0 || log_data[base] !== 32'h11223344) begin nerr++; $display("FAIL rs_writes: got count=%0d want 1 at addr 0", wr_cnt - base); end
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        idle();
        nvec++; if (imem_we !== 1'b1 || imem_waddr !== 4'd0 || imem_wdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL rs_fresh_write: got we=%b addr=%0d data=%h want 1 0 cafef00d", imem_we, imem_waddr, imem_wdata); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hCAFE_F00D);
        idle();
`endif
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rs_fresh_done: got %b want 1", done); end
    endtask

    task automatic test_async_reset();
        int base;
        do_restart();
        base = wr_cnt;
        send_word(32'd3);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            step();
        end
        nvec++; if (imem_waddr !== 4'd1 || imem_wdata !== 32'h9ABCDEF0) begin nerr++; $display("FAIL ar_before: got addr=%0d data=%h want 1 9abcdef0", imem_waddr, imem_wdata); end
        in_valid = 1'($urandom_range(0, 1));
        #2;
        rst = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b0 || imem_we !== 1'b0 || cpu_hold !== 1'b1) begin nerr++; $display("FAIL ar_ctrl: got ready=%b we=%b hold=%b want 0 0 1", in_ready, imem_we, cpu_hold); end
        nvec++; if (imem_waddr !== 4'd0 || imem_wdata !== 32'h0) begin nerr++; $display("FAIL ar_data: got addr=%0d data=%h want 0 0", imem_waddr, imem_wdata); end
        nvec++; if (done !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL ar_status: got done=%b err=%b want 0 0", done, err); end
        idle();
        step();
        rst = 1'b1;
        step();
        nvec++; if (wr_cnt - base !== 2) begin nerr++; $display("FAIL ar_write_count: got %0d want 2", wr_cnt - base); end
        send_word(32'd1);
        send_word(32'h0BAD_F00D);
        idle();
        nvec++; if (imem_we !== 1'b1 || imem_waddr !== 4'd0 || imem_wdata !== 32'h0BADF00D) begin nerr++; $display("FAIL ar_fresh_write: got we=%b addr=%0d data=%h want 1 0 0badf00d", imem_we, imem_waddr, imem_wdata); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0BAD_F00D);
        idle();
`endif
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL ar_fresh_done: got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_zero();
        test_oversize();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
